// File: rtl/qcmd_pkg.sv
// Shared definitions for the shot-loop scheduler: register map, FSM states and
// status bit positions.
package qcmd_pkg;

  localparam logic [2:0] QSC_CTRL     = 3'd0;
  localparam logic [2:0] QSC_NCMD     = 3'd1;
  localparam logic [2:0] QSC_NSHOTS   = 3'd2;
  localparam logic [2:0] QSC_SHOT_LEN = 3'd3;
  localparam logic [2:0] QSC_GAP      = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } qsc_state_t;

  localparam int STS_BUSY        = 0;
  localparam int STS_ERR_TIMEOUT = 1;
  localparam int STS_WR_BLOCKED  = 2;
  localparam int STS_ABORTED     = 3;

endpackage

// File: rtl/qcmd_shot_ctrl_if.sv
// Host local-bus write port of the shot-loop scheduler.
interface qcmd_shot_ctrl_if;
  logic [2:0]  lb_addr;
  logic [31:0] lb_wdata;
  logic        lb_wstrobe;

  modport master (output lb_addr, lb_wdata, lb_wstrobe);
  modport slave  (input  lb_addr, lb_wdata, lb_wstrobe);
endinterface

// File: rtl/qsc_regs.sv
// Write-only run configuration registers, CTRL pulse decode and the shadow
// copy that a run uses while it is active.
module qsc_regs
  import qcmd_pkg::*;
#(
  parameter int cw = 16,
  parameter int tw = 24
) (
  input  logic            clk,
  input  logic            reset,
  qcmd_shot_ctrl_if.slave lb,
  input  logic            i_cap,
  output logic            o_start_req,
  output logic            o_abort,
  output logic            o_clr,
  output logic [cw-1:0]   o_n_shots_live,
  output logic [cw-1:0]   o_n_cmd,
  output logic [cw-1:0]   o_n_shots,
  output logic [tw-1:0]   o_shot_len,
  output logic [tw-1:0]   o_gap
);

  logic [cw-1:0] r_n_cmd, r_n_shots, r_sh_n_cmd, r_sh_n_shots;
  logic [tw-1:0] r_shot_len, r_gap, r_sh_shot_len, r_sh_gap;
  logic          w_ctrl_wr;
  logic          w_unused;

  assign w_ctrl_wr   = lb.lb_wstrobe && (lb.lb_addr == QSC_CTRL);
  assign o_start_req = w_ctrl_wr & lb.lb_wdata[0];
  assign o_abort     = w_ctrl_wr & lb.lb_wdata[1];
  assign o_clr       = w_ctrl_wr & lb.lb_wdata[2];
  assign w_unused    = ^lb.lb_wdata[31:tw];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_cmd    <= '0;
      r_n_shots  <= cw'(1);
      r_shot_len <= '1;
      r_gap      <= '0;
    end else if (lb.lb_wstrobe) begin
      case (lb.lb_addr)
        QSC_NCMD:     r_n_cmd    <= lb.lb_wdata[cw-1:0];
        QSC_NSHOTS:   r_n_shots  <= lb.lb_wdata[cw-1:0];
        QSC_SHOT_LEN: r_shot_len <= lb.lb_wdata[tw-1:0];
        QSC_GAP:      r_gap      <= lb.lb_wdata[tw-1:0];
        default:      ;
      endcase
    end
  end

  // Shadow copy: the run sees only values present when it was accepted
  always_ff @(posedge clk) begin
    if (i_cap) begin
      r_sh_n_cmd    <= r_n_cmd;
      r_sh_n_shots  <= r_n_shots;
      r_sh_shot_len <= r_shot_len;
      r_sh_gap      <= r_gap;
    end
  end

  assign o_n_shots_live = r_n_shots;
  assign o_n_cmd        = r_sh_n_cmd;
  assign o_n_shots      = r_sh_n_shots;
  assign o_shot_len     = r_sh_shot_len;
  assign o_gap          = r_sh_gap;

endmodule

// File: rtl/qcmd_shot_ctrl.sv
// Shot-loop scheduler: triggers the command generator, counts its cstrobes per
// shot, repeats with an inter-shot gap and locks out command memory writes.
module qcmd_shot_ctrl
  import qcmd_pkg::*;
#(
  parameter int cw = 16,
  parameter int tw = 24
) (
  input  logic            clk,
  input  logic            reset,
  qcmd_shot_ctrl_if.slave lb,
  input  logic            ext_start,
  input  logic            cstrobe_in,
  input  logic            cmd_wstrobe_in,
  output logic            cmd_wstrobe_out,
  output logic            trig,
  output logic            busy,
  output logic            done,
  output logic [cw-1:0]   shot_idx,
  output logic [31:0]     status
);

  qsc_state_t    r_state, w_state_nxt;
  logic          r_trig, r_busy, r_done;
  logic          r_err_timeout, r_wr_blocked, r_aborted;
  logic [cw-1:0] r_shot_idx, r_cmd_cnt;
  logic [tw-1:0] r_run_cnt, r_gap_cnt;

  logic          w_start_req, w_abort, w_clr, w_accept, w_zero_shots;
  logic          w_cmd_hit, w_timeout, w_shot_end, w_last_shot, w_gap_done, w_blocked;
  logic [cw-1:0] w_n_shots_live, w_n_cmd, w_n_shots;
  logic [tw-1:0] w_shot_len, w_gap;
  logic          w_ctrl_start;

  qsc_regs #(.cw(cw), .tw(tw)) u_regs (
    .clk            (clk),
    .reset          (reset),
    .lb             (lb),
    .i_cap          (w_accept),
    .o_start_req    (w_ctrl_start),
    .o_abort        (w_abort),
    .o_clr          (w_clr),
    .o_n_shots_live (w_n_shots_live),
    .o_n_cmd        (w_n_cmd),
    .o_n_shots      (w_n_shots),
    .o_shot_len     (w_shot_len),
    .o_gap          (w_gap)
  );

  assign w_start_req  = ext_start | w_ctrl_start;
  assign w_accept     = w_start_req & ~w_abort & (r_state == ST_IDLE);
  assign w_zero_shots = (w_n_shots_live == '0);

  // A zero command count ends the shot on its first RUN cycle regardless of cstrobe
  assign w_cmd_hit   = (w_n_cmd == '0) ||
                       (({1'b0, r_cmd_cnt} + {{cw{1'b0}}, cstrobe_in}) == {1'b0, w_n_cmd});
  assign w_timeout   = (r_run_cnt == w_shot_len);
  assign w_shot_end  = (r_state == ST_RUN) & (w_cmd_hit | w_timeout);
  assign w_last_shot = (r_shot_idx == w_n_shots - cw'(1));
  assign w_gap_done  = (r_gap_cnt == w_gap - tw'(1));
  assign w_blocked   = cmd_wstrobe_in & r_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_zero_shots) w_state_nxt = ST_TRIG;
      ST_TRIG: w_state_nxt = ST_RUN;
      ST_RUN:
        if (w_shot_end) begin
          if (w_last_shot)        w_state_nxt = ST_IDLE;
          else if (w_gap == '0)   w_state_nxt = ST_TRIG;
          else                    w_state_nxt = ST_GAP;
        end
      ST_GAP:  if (w_gap_done) w_state_nxt = ST_TRIG;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_trig        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shot_idx    <= '0;
      r_err_timeout <= 1'b0;
      r_wr_blocked  <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_trig  <= (w_state_nxt == ST_TRIG);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= ~w_abort & ((w_accept & w_zero_shots) | (w_shot_end & w_last_shot));
      if (!w_abort) begin
        if (w_accept && !w_zero_shots) r_shot_idx <= '0;
        else if (w_shot_end && !w_last_shot) r_shot_idx <= r_shot_idx + cw'(1);
      end
      // Sticky bits: a set in the same cycle as clr takes priority
      r_err_timeout <= (r_err_timeout & ~w_clr) | (w_shot_end & w_timeout & ~w_cmd_hit);
      r_wr_blocked  <= (r_wr_blocked & ~w_clr) | w_blocked;
      r_aborted     <= (r_aborted & ~w_clr) | w_abort;
    end
  end

  // Shot counters; cleared on the TRIG cycle so they need no reset
  always_ff @(posedge clk) begin
    if (r_state == ST_TRIG) begin
      r_cmd_cnt <= '0;
      r_run_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (cstrobe_in) r_cmd_cnt <= r_cmd_cnt + cw'(1);
      if (!w_timeout) r_run_cnt <= r_run_cnt + tw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + tw'(1);
    else                   r_gap_cnt <= '0;
  end

  assign cmd_wstrobe_out = cmd_wstrobe_in & ~r_busy;
  assign trig            = r_trig;
  assign busy            = r_busy;
  assign done            = r_done;
  assign shot_idx        = r_shot_idx;

  always_comb begin
    status                  = '0;
    status[STS_BUSY]        = r_busy;
    status[STS_ERR_TIMEOUT] = r_err_timeout;
    status[STS_WR_BLOCKED]  = r_wr_blocked;
    status[STS_ABORTED]     = r_aborted;
  end

endmodule

// File: doc/qcmd_shot_ctrl.md
# qcmd_shot_ctrl

Shot-loop scheduler for the qubit command generator. It holds the run configuration in a small local-bus register file. It issues the `trig` pulse that restarts the command generator's time counter and play pointer, and counts the generator's `cstrobe` outputs to detect end of shot. It repeats the shot a programmed number of times with an inter-shot gap, and blocks host writes to command memory while a run is active. It sits between the host local bus and the command generator, one instance per generator.

## Interface
Parameters:
- `cw`, 16: width of command count and shot count.
- `tw`, 24: width of timeout and gap counters; matches the generator's 24-bit time field.

Ports:
- `clk` input 1: single clock. All logic is in this domain.
- `reset` input 1: synchronous, active-high.
- `lb_addr` input 3: register select.
- `lb_wdata` input 32: register write data.
- `lb_wstrobe` input 1: register write strobe.
- `ext_start` input 1: hardware start pulse.
- `cstrobe_in` input 1: `cstrobe` from the command generator.
- `cmd_wstrobe_in` input 1: host write strobe intended for command memory.
- `cmd_wstrobe_out` output 1: gated write strobe to the generator's `wstrobe`.
- `trig` output 1: one-cycle restart pulse to the generator.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse when a run completes normally.
- `shot_idx` output `cw`: index of the current or last shot.
- `status` output 32: {28'b0, `aborted`, `wr_blocked`, `err_timeout`, `busy`}. Bits 1–3 are sticky.

## Operation
Registers are write-only via the local bus; readback goes through `status` and `shot_idx`. Reset values are given in parentheses.
- Address 0, CTRL:
  - bit0 `start`: self-clearing pulse.
  - bit1 `abort`: self-clearing pulse.
  - bit2 `clr`: clears all sticky status bits.
- Address 1, `n_cmd` (0): cstrobes per shot, `cw` bits.
- Address 2, `n_shots` (1): shots per run, `cw` bits.
- Address 3, `shot_len` (all ones): per-shot timeout in cycles, `tw` bits.
- Address 4, `gap` (0): idle cycles between shots, `tw` bits.
- Addresses 5–7: writes ignored.

Start and configuration capture:
- The start condition is `ext_start` OR a CTRL write with bit0 set.
- On an accepted start, `n_cmd`, `n_shots`, `shot_len` and `gap` are copied into shadow registers. Register writes during a run affect only the next run.

State machine: IDLE, TRIG, RUN, GAP.
- IDLE:
  - Start with `n_shots` ≠ 0: go to TRIG, `shot_idx` ← 0.
  - Start with `n_shots` = 0: stay in IDLE and pulse `done` next cycle.
- TRIG: lasts exactly one cycle; `cmd_cnt` and `run_cnt` clear; go to RUN.
- RUN:
  - `cmd_cnt` increments on each `cstrobe_in`; `run_cnt` increments every cycle.
  - The shot ends when (`cmd_cnt` + `cstrobe_in`) == `n_cmd`. With `n_cmd` = 0 the shot ends in the first RUN cycle.
  - If `run_cnt` == `shot_len` first, set `err_timeout` and end the shot.
  - On shot end with `shot_idx` == `n_shots` − 1: go to IDLE and pulse `done`.
  - On any other shot end: go to GAP, or straight to TRIG if `gap` = 0, with `shot_idx` +1.
- GAP: counts `gap` cycles, then goes to TRIG.
- `cstrobe_in` outside RUN is ignored.
- `cmd_wstrobe_out` = `cmd_wstrobe_in` & ~`busy`. A blocked write sets `wr_blocked`.
- Abort (CTRL bit1) in any state:
  - Go to IDLE next cycle and set `aborted`.
  - No `done` pulse; `shot_idx` holds its value.
  - Abort wins over a simultaneous start.
- A start while `busy` is ignored.
- `clr` in the same cycle as a setting event: the set wins.

## Timing
- All outputs are registered except `cmd_wstrobe_out`, which is combinational.
- Reset values: `trig` = 0, `busy` = 0, `done` = 0, `shot_idx` = 0, `status` = 0, state = IDLE.
- Reset mid-run returns to IDLE in one cycle; no `done`, no `trig`.
- Start accepted at edge t: `trig` and `busy` are high in cycle t+1; RUN begins at t+2.
- Shot spacing:
  - The last RUN cycle is followed by `gap` GAP cycles, then one TRIG cycle.
  - Successive `trig` pulses are therefore spaced (RUN length + `gap` + 1) cycles apart.
- Final shot end at edge t: `busy` falls and `done` rises together in cycle t+1.
- Counter behaviour:
  - Counters never wrap within a shot; `run_cnt` saturates at the timeout compare.
  - `cmd_cnt` width is `cw`; cstrobes beyond `n_cmd` cannot occur because the state leaves RUN.

## Structure
- Shared package `qcmd_pkg`:
  - Register address constants `QSC_CTRL` … `QSC_GAP`.
  - State enum `qsc_state_t`.
  - Status bit-index constants.
- Natural sub-module `qsc_regs`: the local-bus register file with self-clearing pulses and shadow capture. The FSM and counters stay in the top level.

## Test plan
1. Single shot: `n_cmd` = 3, `n_shots` = 1, `shot_len` = 100; CTRL = 1; three `cstrobe_in` pulses at RUN cycles 5/9/20 → `trig` once in cycle t+1, `done` in the cycle after the third pulse, `err_timeout` = 0.
2. Repeat with gap: `n_cmd` = 2, `n_shots` = 3, `gap` = 4, immediate cstrobes → three `trig` pulses, `shot_idx` 0,1,2, exactly 4 idle cycles after each of the first two shots, one `done`.
3. Timeout: `n_cmd` = 5, `shot_len` = 10, only 2 cstrobes → shot ends at `run_cnt` = 10, `status[1]` = 1, run proceeds to the next shot.
4. Abort: abort during GAP of shot 1 of 4 → `busy` falls next cycle, no `done`, `status[3]` = 1, `shot_idx` = 1; simultaneous start and abort in IDLE → stays IDLE.
5. Write lockout: `cmd_wstrobe_in` while busy → `cmd_wstrobe_out` = 0, `status[2]` = 1; the same write in IDLE passes through; `clr` zeros bits 1–3.
6. Edge cases:
   - `n_shots` = 0 → `done` with no `trig`.
   - Register write of `n_cmd` mid-run → current run uses the old value.
   - Synchronous `reset` in RUN → all outputs 0 next cycle.
